if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
// - Instruction-fetch stage: owns the PC register, drives the external 32-bit PC+4 adder, issues
//   instruction-memory reads and loads the IF/ID pipeline register.
// - Sits directly upstream of the PC+4 adder (pc_o -> adder A, 32'd4 -> adder B, adder C -> pc_plus4_i)
//   and feeds the decode stage.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PC loaded on reset
// - NOP_INSTR  32'h0000_0000  instruction word presented to ID when IF/ID is invalid
// PORTS
// - clk           in   1   clock, all state updates on posedge
// - rst           in   1   synchronous reset, active-high
// - stall_i       in   1   ID/hazard unit: hold IF/ID contents
// - redirect_i    in   1   branch/jump taken: flush and reload PC
// - redirect_pc_i in   32  redirect target
// - pc_o          out  32  current PC, to PC+4 adder input A
// - pc_plus4_i    in   32  PC+4 from adder output C (combinational from pc_o)
// - imem_req_o    out  1   instruction read request
// - imem_addr_o   out  32  read address, {addr[31:2],2'b00}
// - imem_rdata_i  in   32  read data, valid with imem_rvalid_i
// - imem_rvalid_i in   1   read complete (same cycle as request or later)
// - if_id_valid_o out  1   IF/ID holds a real instruction
// - if_id_pc_o    out  32  PC of instruction in IF/ID
// - if_id_pc4_o   out  32  PC+4 of instruction in IF/ID
// - if_id_instr_o out  32  instruction in IF/ID (NOP_INSTR when invalid)
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=FETCH, imem_req_o=0 during rst, if_id_valid_o=0, if_id_pc_o=0,
//   if_id_pc4_o=0, if_id_instr_o=NOP_INSTR, hold buffer cleared. Reset mid-transaction drops it.
// - One outstanding read max; imem_req_o and imem_addr_o held stable until imem_rvalid_i.
// - FETCH: imem_req_o=1, imem_addr_o=pc.
//   - rvalid & !stall: IF/ID <= {1,pc,pc_plus4_i,rdata}; pc <= pc_plus4_i; stay FETCH (1 instr/cycle
//     when memory answers same cycle).
//   - rvalid & stall: IF/ID unchanged; rdata,pc,pc_plus4_i -> hold buffer; pc <= pc_plus4_i; go HOLD.
//   - !rvalid & !stall: IF/ID valid <= 0 (bubble). !rvalid & stall: IF/ID unchanged.
// - HOLD: imem_req_o=0. When stall_i falls: IF/ID <= hold buffer, go FETCH same edge.
// - DRAIN: imem_req_o=1, imem_addr_o=saved old address; on rvalid discard data, go FETCH.
// - redirect_i has priority over stall_i and rvalid in every state:
//   - pc <= {redirect_pc_i[31:2],2'b00}; IF/ID valid <= 0, instr <= NOP_INSTR, pc fields <= 0.
//   - FETCH & rvalid: data dropped, next state FETCH. FETCH & !rvalid: next state DRAIN.
//   - HOLD: buffer discarded, FETCH. DRAIN: new target replaces pc, stays DRAIN.
// - No internal adder: pc_plus4_i wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no special case.
// - pc_o always equals the PC register (registered output, no combinational path from inputs).
// CONFIGURATION
// - FETCH_MISALIGN_TRAP_EN defined: extra output if_id_misalign_o (1 bit, reset 0). Redirect with
//   redirect_pc_i[1:0]!=0 loads pc unaligned target, state -> MISALIGN: no imem request; next
//   non-stalled cycle IF/ID <= {valid=1,pc,pc_plus4_i,NOP_INSTR}, misalign=1; then stays MISALIGN
//   (idle) until next redirect. misalign clears whenever IF/ID loads a normal entry or flushes.
// - Not defined: no port; low two redirect bits silently forced to 0.
// TESTING
// - rst 2 cycles, mem answers same cycle -> pc_o 0,4,8,C; if_id_pc_o follows one cycle behind, valid=1.
// - stall_i high 3 cycles while rvalid at pc=8 -> HOLD, imem_req_o=0, IF/ID stays pc=4; release -> pc=8.
// - 2-cycle memory, redirect_i to 0x100 while waiting on 0x10 -> DRAIN, old data dropped,
//   next request addr 0x100, IF/ID valid=0 until 0x100 returns.
// - redirect_i and stall_i same cycle in HOLD -> buffer dropped, IF/ID valid=0, next addr = target.
// - RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0000_0000.
// - FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> no imem_req, IF/ID pc=0x102, instr=NOP, misalign=1.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory read sequencing and the IF/ID register.
// Optional misaligned-redirect trap is built when FETCH_MISALIGN_TRAP_EN is defined.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_rvalid_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        if_id_misalign_o,
`endif
    output logic [31:0] if_id_instr_o
);

    // Memory handshake: a read is issued while imem_req_o is high and completes on the
    // cycle imem_rvalid_i is high (possibly the same cycle); req/addr never change meanwhile.
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_HOLD  = 3'd1,
        S_DRAIN = 3'd2,
        S_TRAP  = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_pc4;
    logic [31:0] hold_instr;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    logic [31:0] redirect_pc;
    logic        tgt_misaligned;
    logic        pc_misaligned;

    logic        pc_redirect;
    logic        pc_adv;
    logic        drain_capture;
    logic        hold_load;
    logic        ifid_flush;
    logic        ifid_load;
    logic        ifid_from_hold;
    logic        ifid_bubble;
    logic        trap_load;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;

    assign redirect_pc    = redirect_pc_i;
    assign tgt_misaligned = (redirect_pc_i[1:0] != 2'b00);
    assign pc_misaligned  = (pc[1:0] != 2'b00);
`else
    // Without the trap, the low address bits of a redirect are simply ignored.
    assign redirect_pc    = redirect_pc_i & ~32'd3;
    assign tgt_misaligned = 1'b0;
    assign pc_misaligned  = 1'b0;
`endif

    always_ff @(posedge clk) begin : state_register
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        if (redirect_i) begin
            case (state)
                S_FETCH: begin
                    if (!imem_rvalid_i) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next = tgt_misaligned ? S_TRAP : S_FETCH;
                    end
                end
                S_DRAIN: state_next = S_DRAIN;
                default: state_next = tgt_misaligned ? S_TRAP : S_FETCH;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rvalid_i && stall_i) begin
                        state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        state_next = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid_i) begin
                        state_next = pc_misaligned ? S_TRAP : S_FETCH;
                    end
                end
                S_TRAP: begin
                    if (!stall_i) begin
                        state_next = S_IDLE;
                    end
                end
                S_IDLE:  state_next = S_IDLE;
                default: state_next = S_FETCH;
            endcase
        end
    end

    always_comb begin : output_logic
        imem_req_o     = 1'b0;
        imem_addr_o    = {pc[31:2], 2'b00};
        pc_redirect    = 1'b0;
        pc_adv         = 1'b0;
        drain_capture  = 1'b0;
        hold_load      = 1'b0;
        ifid_flush     = 1'b0;
        ifid_load      = 1'b0;
        ifid_from_hold = 1'b0;
        ifid_bubble    = 1'b0;
        trap_load      = 1'b0;

        case (state)
            S_FETCH: imem_req_o = !rst;
            S_DRAIN: begin
                imem_req_o  = !rst;
                imem_addr_o = drain_addr;
            end
            default: ;
        endcase

        if (redirect_i) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            // An abandoned read still has to be completed at its original address.
            if (state == S_FETCH && !imem_rvalid_i) begin
                drain_capture = 1'b1;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rvalid_i) begin
                        pc_adv = 1'b1;
                        if (stall_i) begin
                            hold_load = 1'b1;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall_i) begin
                        ifid_bubble = 1'b1;
                    end
                end
                S_HOLD:  ifid_from_hold = !stall_i;
                S_TRAP:  trap_load      = !stall_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin : pc_and_buffers
        if (rst) begin
            pc         <= RESET_PC;
            drain_addr <= 32'h0000_0000;
            hold_pc    <= 32'h0000_0000;
            hold_pc4   <= 32'h0000_0000;
            hold_instr <= NOP_INSTR;
        end else begin
            if (pc_redirect) begin
                pc <= redirect_pc;
            end else if (pc_adv) begin
                pc <= pc_plus4_i;
            end
            if (drain_capture) begin
                drain_addr <= {pc[31:2], 2'b00};
            end
            if (hold_load) begin
                hold_pc    <= pc;
                hold_pc4   <= pc_plus4_i;
                hold_instr <= imem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin : if_id_register
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'h0000_0000;
            ifid_pc4   <= 32'h0000_0000;
            ifid_instr <= NOP_INSTR;
        end else if (ifid_flush) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'h0000_0000;
            ifid_pc4   <= 32'h0000_0000;
            ifid_instr <= NOP_INSTR;
        end else if (ifid_load) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4_i;
            ifid_instr <= imem_rdata_i;
        end else if (ifid_from_hold) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= hold_pc;
            ifid_pc4   <= hold_pc4;
            ifid_instr <= hold_instr;
        end else if (trap_load) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4_i;
            ifid_instr <= NOP_INSTR;
        end else if (ifid_bubble) begin
            ifid_valid <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin : misalign_flag
        if (rst) begin
            misalign <= 1'b0;
        end else if (ifid_flush || ifid_load || ifid_from_hold) begin
            misalign <= 1'b0;
        end else if (trap_load) begin
            misalign <= 1'b1;
        end
    end

    assign if_id_misalign_o = misalign;
`endif

    assign pc_o          = pc;
    assign if_id_valid_o = ifid_valid;
    assign if_id_pc_o    = ifid_pc;
    assign if_id_pc4_o   = ifid_pc4;
    assign if_id_instr_o = ifid_valid ? ifid_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed fetch/stall/redirect scenarios, then random traffic
// against a transaction-level model with a variable-latency instruction memory.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_rvalid_i = 1'b0;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_id_misalign_o;
    logic        w_misalign;
`endif

    logic [31:0] w_pc, w_pc4, w_addr, w_ifid_pc, w_ifid_pc4, w_instr;
    logic        w_req, w_valid;

    int n_cmp = 0;
    int n_err = 0;

    // environment state
    int          lat_mode = 0;
    bit          use_model = 1'b1;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = '0;

    // reference model state
    logic [31:0] m_pc;
    ent_t        m_ifid;
    ent_t        held_q[$];
    bit          m_draining;
    logic [31:0] m_drain_addr;

    always #5 clk = ~clk;

    assign pc_plus4_i = pc_o + 32'd4;
    assign w_pc4      = w_pc + 32'd4;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .pc_o(pc_o), .pc_plus4_i(pc_plus4_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .imem_rvalid_i(imem_rvalid_i), .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o),
        .if_id_pc4_o(if_id_pc4_o),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_id_misalign_o(if_id_misalign_o),
`endif
        .if_id_instr_o(if_id_instr_o)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0000_0000), .pc_o(w_pc), .pc_plus4_i(w_pc4),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(32'h0000_0033),
        .imem_rvalid_i(w_req), .if_id_valid_o(w_valid), .if_id_pc_o(w_ifid_pc),
        .if_id_pc4_o(w_ifid_pc4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_id_misalign_o(w_misalign),
`endif
        .if_id_instr_o(w_instr)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = 32'h0000_0000;
        m_ifid       = '0;
        m_draining   = 1'b0;
        m_drain_addr = '0;
        held_q.delete();
    endtask

    // One clock of the fetch stage described as instruction movement, not as states.
    task automatic model_step(input bit s, input bit r, input logic [31:0] tgt, input bit rv);
        logic [31:0] a;
        ent_t        e;
        a = m_draining ? m_drain_addr : {m_pc[31:2], 2'b00};
        if (r) begin
            if (!m_draining && held_q.size() == 0 && !rv) begin
                m_draining   = 1'b1;
                m_drain_addr = a;
            end
            held_q.delete();
            m_ifid = '0;
            m_pc   = {tgt[31:2], 2'b00};
        end else if (held_q.size() != 0) begin
            if (!s) m_ifid = held_q.pop_front();
        end else if (m_draining) begin
            if (rv) m_draining = 1'b0;
        end else if (rv) begin
            e = '{v: 1'b1, pc: m_pc, pc4: m_pc + 32'd4, instr: mem_fn(a)};
            if (s) held_q.push_back(e);
            else m_ifid = e;
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_ifid.v = 1'b0;
        end
    endtask

    task automatic model_compare();
        chk("pc_o", pc_o, m_pc);
        chk("imem_req", {31'b0, imem_req_o}, {31'b0, held_q.size() == 0});
        if (held_q.size() == 0)
            chk("imem_addr", imem_addr_o, m_draining ? m_drain_addr : {m_pc[31:2], 2'b00});
        chk("ifid_valid", {31'b0, if_id_valid_o}, {31'b0, m_ifid.v});
        chk("ifid_pc", if_id_pc_o, m_ifid.pc);
        chk("ifid_pc4", if_id_pc4_o, m_ifid.pc4);
        chk("ifid_instr", if_id_instr_o, m_ifid.v ? m_ifid.instr : NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("ifid_misalign", {31'b0, if_id_misalign_o}, 32'd0);
`endif
    endtask

    task automatic cycle(input bit s, input bit r, input logic [31:0] tgt);
        bit rv;
        @(negedge clk);
        rst = 1'b0;
        stall_i = s;
        redirect_i = r;
        redirect_pc_i = tgt;
        #1;
        rv = 1'b0;
        if (imem_req_o) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_lat  = (lat_mode < 0) ? $urandom_range(0, 2) : lat_mode;
                mem_addr = imem_addr_o;
            end else begin
                chk("addr_hold", imem_addr_o, mem_addr);
            end
            rv = (mem_cnt >= mem_lat);
        end
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_fn(imem_addr_o) : $urandom();
        if (use_model) model_step(s, r, tgt, rv);
        @(posedge clk);
        #1;
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt++;
        if (use_model) model_compare();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, 32'h0000_0000);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, if_id_valid_o}, 32'd0);
        chk("rst_ifid_pc", if_id_pc_o, 32'd0);
        chk("rst_ifid_pc4", if_id_pc4_o, 32'd0);
        chk("rst_instr", if_id_instr_o, NOP);
        mem_busy = 1'b0;
        model_reset();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] tgt;
        bit s, r;

        // reset and back-to-back fetches with a same-cycle memory
        model_reset();
        lat_mode = 0;
        do_reset(2);
        chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("seq_pc1", pc_o, 32'h4);
        chk("seq_ifid0", if_id_pc_o, 32'h0);
        chk("wrap_pc", w_pc, 32'h0000_0000);
        chk("wrap_addr", w_addr, 32'h0000_0000);
        chk("wrap_ifid_pc", w_ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_pc4", w_ifid_pc4, 32'h0000_0000);
        cycle(0, 0, 0);
        chk("seq_pc2", pc_o, 32'h8);
        chk("seq_ifid4", if_id_pc_o, 32'h4);

        // stall while the read of 0x8 completes
        cycle(1, 0, 0);
        chk("hold_req", {31'b0, imem_req_o}, 32'd0);
        chk("hold_ifid", if_id_pc_o, 32'h4);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("hold_ifid_still", if_id_pc_o, 32'h4);
        cycle(0, 0, 0);
        chk("release_ifid", if_id_pc_o, 32'h8);
        chk("release_pc", pc_o, 32'hC);

        // redirect while a slow read is outstanding
        cycle(0, 0, 0);
        lat_mode = 2;
        cycle(0, 0, 0);
        cycle(0, 1, 32'h100);
        chk("drain_addr", imem_addr_o, 32'h10);
        chk("drain_pc", pc_o, 32'h100);
        cycle(0, 0, 0);
        chk("drained_addr", imem_addr_o, 32'h100);
        chk("drained_valid", {31'b0, if_id_valid_o}, 32'd0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("target_ifid", if_id_pc_o, 32'h100);
        chk("target_valid", {31'b0, if_id_valid_o}, 32'd1);

        // redirect and stall together while holding
        lat_mode = 0;
        cycle(1, 0, 0);
        cycle(1, 1, 32'h200);
        chk("hold_redir_valid", {31'b0, if_id_valid_o}, 32'd0);
        chk("hold_redir_addr", imem_addr_o, 32'h200);
        chk("hold_redir_req", {31'b0, imem_req_o}, 32'd1);
        cycle(0, 0, 0);

`ifdef FETCH_MISALIGN_TRAP_EN
        do_reset(1);
        use_model = 1'b0;
        cycle(0, 1, 32'h102);
        chk("mis_pc", pc_o, 32'h102);
        chk("mis_req", {31'b0, imem_req_o}, 32'd0);
        cycle(0, 0, 0);
        chk("mis_valid", {31'b0, if_id_valid_o}, 32'd1);
        chk("mis_ifid_pc", if_id_pc_o, 32'h102);
        chk("mis_ifid_pc4", if_id_pc4_o, 32'h106);
        chk("mis_instr", if_id_instr_o, NOP);
        chk("mis_flag", {31'b0, if_id_misalign_o}, 32'd1);
        cycle(0, 0, 0);
        chk("mis_idle_req", {31'b0, imem_req_o}, 32'd0);
        cycle(0, 1, 32'h200);
        chk("mis_clear", {31'b0, if_id_misalign_o}, 32'd0);
        chk("mis_exit_addr", imem_addr_o, 32'h200);
        do_reset(1);
        use_model = 1'b1;
`endif

        // random traffic
        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                s = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 99) < 8);
                tgt = $urandom();
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt = tgt & ~32'd3;
`endif
                cycle(s, r, tgt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
